// File: rtl/pc_ctrl_pipe.sv
// pc_ctrl_pipe
//   Program-counter controller for the pipelined core. It holds the PC and
//   the Z/V/N flag register, and it resolves conditional PC-relative (B,
//   opcode 1100) and register (BR, opcode 1101) branches. A taken branch
//   raises flush so the younger fetched instruction is squashed. A halt
//   (opcode 1111) moves a RUN -> DRAIN -> HALTED machine so in-flight work
//   retires before hlt is raised.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   stall        hold the PC and suppress branch/halt action this cycle
//   instr        instruction in decode: opcode [15:12], cond [11:9],
//                offset [OFF_W-1:0]
//   instr_valid  instr is real (0 = bubble; bubbles still advance the PC)
//   rs_reg       register target for BR
//   fl           execute flags {Z,V,N}
//   fl_op        opcode of the instruction that produced fl
//   fl_valid     fl / fl_op are valid this cycle
//   pc           registered PC
//   pc_inc       pc + INC
//   taken        branch taken this cycle (combinational)
//   flush        squash the younger instruction (equal to taken)
//   halting      state is DRAIN
//   hlt          state is HALTED
module pc_ctrl_pipe #(
  parameter int              PC_W      = 16,
  parameter int              OFF_W     = 9,
  parameter int              INC       = 2,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              DRAIN_CYC = 3,
  parameter int              BYPASS    = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [15:0]     instr,
  input  logic            instr_valid,
  input  logic [PC_W-1:0] rs_reg,
  input  logic [2:0]      fl,
  input  logic [3:0]      fl_op,
  input  logic            fl_valid,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_inc,
  output logic            taken,
  output logic            flush,
  output logic            halting,
  output logic            hlt
);

  // The counter only ever holds values 0 .. DRAIN_CYC-1.
  localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_HALTED  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [PC_W-1:0]   pc_reg, pc_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              z_reg, v_reg, n_reg;

  logic [3:0]        opcode;
  logic [2:0]        cond;
  logic              is_b, is_br, is_hlt;
  logic              wr_zvn, wr_z;
  logic              z_eff, v_eff, n_eff;
  logic              cond_true;
  logic [PC_W-1:0]   off_ext;
  logic [PC_W-1:0]   b_target;
  logic [PC_W-1:0]   target;

  assign opcode = instr[15:12];
  assign cond   = instr[11:9];
  assign is_b   = (opcode == 4'b1100);
  assign is_br  = (opcode == 4'b1101);
  assign is_hlt = (opcode == 4'b1111);

  // fl_op 0000/0001 write all three flags, 0010/0011 write Z only.
  assign wr_zvn = fl_valid && (fl_op[3:1] == 3'b000);
  assign wr_z   = fl_valid && (fl_op[3:2] == 2'b00);

  // With forwarding enabled, a flag being written this cycle is seen by
  // the branch in decode without waiting for the register.
  assign z_eff = ((BYPASS != 0) && wr_z)   ? fl[2] : z_reg;
  assign v_eff = ((BYPASS != 0) && wr_zvn) ? fl[1] : v_reg;
  assign n_eff = ((BYPASS != 0) && wr_zvn) ? fl[0] : n_reg;

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      3'b000:  cond_true = !z_eff;
      3'b001:  cond_true = z_eff;
      3'b010:  cond_true = !z_eff && !n_eff;
      3'b011:  cond_true = n_eff;
      3'b100:  cond_true = z_eff || (!z_eff && !n_eff);
      3'b101:  cond_true = z_eff || n_eff;
      3'b110:  cond_true = v_eff;
      default: cond_true = 1'b1;
    endcase
  end

  assign pc_inc   = pc_reg + PC_W'(INC);
  // Offset counts half-words: sign-extend, then scale by two.
  assign off_ext  = {{(PC_W-OFF_W){instr[OFF_W-1]}}, instr[OFF_W-1:0]};
  assign b_target = pc_inc + {off_ext[PC_W-2:0], 1'b0};
  assign target   = is_br ? rs_reg : b_target;

  assign taken   = (state_reg == ST_RUN) && instr_valid && !stall
                   && (is_b || is_br) && cond_true;
  assign flush   = taken;
  assign pc      = pc_reg;
  assign halting = (state_reg == ST_DRAIN);
  assign hlt     = (state_reg == ST_HALTED);

  // Next PC / state. Outside RUN the PC is frozen; DRAIN counts down
  // regardless of stall.
  always_comb begin
    pc_next    = pc_reg;
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_RUN: begin
        if (!stall) begin
          if (instr_valid && is_hlt) begin
            state_next = ST_DRAIN;
            cnt_next   = DRAIN_LOAD;
          end else if (taken) begin
            pc_next = target;
          end else begin
            pc_next = pc_inc;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_reg == '0) begin
          state_next = ST_HALTED;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_HALTED: begin
        state_next = ST_HALTED;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= RESET_PC;
      state_reg <= ST_RUN;
      cnt_reg   <= '0;
    end else begin
      pc_reg    <= pc_next;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Flags are written from execute independently of stall and state.
  always_ff @(posedge clk) begin
    if (rst) begin
      z_reg <= 1'b0;
      v_reg <= 1'b0;
      n_reg <= 1'b0;
    end else begin
      if (wr_z) begin
        z_reg <= fl[2];
      end
      if (wr_zvn) begin
        v_reg <= fl[1];
        n_reg <= fl[0];
      end
    end
  end

endmodule

// File: tb/tb_pc_ctrl_pipe.sv
// tb_pc_ctrl_pipe
//   Drives two copies of pc_ctrl_pipe (forwarding on and off) with the same
//   stimulus. Each transaction drives inputs on the falling edge, checks the
//   combinational taken/flush, pushes the expected post-edge PC and FSM
//   outputs to a queue, and pops/compares them after the rising edge.
module tb_pc_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic [15:0] rs_reg = '0;
  logic [2:0]  fl = '0;
  logic [3:0]  fl_op = '0;
  logic        fl_valid = 1'b0;

  logic [15:0] pc1, pc_inc1, pc0, pc_inc0;
  logic        taken1, flush1, halting1, hlt1;
  logic        taken0, flush0, halting0, hlt0;

  int checks = 0;
  int failures = 0;
  int txn = 0;

  typedef struct {
    logic [15:0] pc1;
    logic [15:0] pc0;
    logic        halting;
    logic        hlt;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  pc_ctrl_pipe #(.BYPASS(1)) u_dut1 (
    .clk(clk), .rst(rst), .stall(stall), .instr(instr),
    .instr_valid(instr_valid), .rs_reg(rs_reg), .fl(fl), .fl_op(fl_op),
    .fl_valid(fl_valid), .pc(pc1), .pc_inc(pc_inc1), .taken(taken1),
    .flush(flush1), .halting(halting1), .hlt(hlt1)
  );

  pc_ctrl_pipe #(.BYPASS(0)) u_dut0 (
    .clk(clk), .rst(rst), .stall(stall), .instr(instr),
    .instr_valid(instr_valid), .rs_reg(rs_reg), .fl(fl), .fl_op(fl_op),
    .fl_valid(fl_valid), .pc(pc0), .pc_inc(pc_inc0), .taken(taken0),
    .flush(flush0), .halting(halting0), .hlt(hlt0)
  );

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // t1/t0: expected taken for the forwarding / non-forwarding copy,
  // -1 skips the combinational check (used while reset state is unknown).
  task automatic step(input logic r, input logic s, input logic v,
                      input logic [15:0] ins, input logic [15:0] rs,
                      input logic fv, input logic [3:0] fo,
                      input logic [2:0] f, input int t1, input int t0,
                      input logic [15:0] p1, input logic [15:0] p0,
                      input logic hg, input logic hl);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst = r; stall = s; instr_valid = v; instr = ins; rs_reg = rs;
    fl_valid = fv; fl_op = fo; fl = f;
    #1;
    if (t1 >= 0) begin
      check_val("taken_byp", {31'd0, taken1}, t1[31:0]);
      check_val("flush_byp", {31'd0, flush1}, t1[31:0]);
    end
    if (t0 >= 0) begin
      check_val("taken_nobyp", {31'd0, taken0}, t0[31:0]);
      check_val("pc_inc_nobyp", {16'd0, pc_inc0}, {16'd0, pc0 + 16'd2});
    end
    e.pc1 = p1; e.pc0 = p0; e.halting = hg; e.hlt = hl;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check_val("pc_byp", {16'd0, pc1}, {16'd0, got.pc1});
    check_val("pc_nobyp", {16'd0, pc0}, {16'd0, got.pc0});
    check_val("halting", {30'd0, halting1, halting0}, {30'd0, got.halting, got.halting});
    check_val("hlt", {30'd0, hlt1, hlt0}, {30'd0, got.hlt, got.hlt});
    txn++;
    $display("txn %0d rst=%0b stall=%0b v=%0b instr=%h pc=%h/%h taken=%0b/%0b halting=%0b hlt=%0b",
             txn, r, s, v, ins, pc1, pc0, taken1, taken0, halting1, hlt1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset and sequential advance with bubbles.
    step(1,0,0,16'h0000,16'h0,0,4'h0,3'b000,-1,-1,16'h0000,16'h0000,0,0);
    step(0,0,0,16'h0000,16'h0,0,4'h0,3'b000, 0, 0,16'h0002,16'h0002,0,0);
    step(0,0,0,16'h0000,16'h0,0,4'h0,3'b000, 0, 0,16'h0004,16'h0004,0,0);
    step(0,0,0,16'h0000,16'h0,0,4'h0,3'b000, 0, 0,16'h0006,16'h0006,0,0);
    step(0,0,0,16'h0000,16'h0,0,4'h0,3'b000, 0, 0,16'h0008,16'h0008,0,0);
    step(0,0,0,16'h0000,16'h0,0,4'h0,3'b000, 0, 0,16'h000A,16'h000A,0,0);
    step(1,0,0,16'h0000,16'h0,0,4'h0,3'b000, 0, 0,16'h0000,16'h0000,0,0);

    // BR to 0x10, then B with offset -2 (stalled, then unstalled).
    step(0,0,1,16'hDE00,16'h0010,0,4'h0,3'b000,1,1,16'h0010,16'h0010,0,0);
    step(0,1,1,16'hC1FE,16'h0000,0,4'h0,3'b000,0,0,16'h0010,16'h0010,0,0);
    step(0,0,1,16'hC1FE,16'h0000,0,4'h0,3'b000,1,1,16'h000E,16'h000E,0,0);

    // Forwarding: Z written to 1 in the same cycle as a cond-001 branch.
    step(0,0,1,16'hDE00,16'h0020,0,4'h0,3'b000,1,1,16'h0020,16'h0020,0,0);
    step(0,0,1,16'hC204,16'h0000,1,4'b0001,3'b100,1,0,16'h002A,16'h0022,0,0);
    step(1,0,0,16'h0000,16'h0000,0,4'h0,3'b000,0,0,16'h0000,16'h0000,0,0);

    // Flag write enables: Z-only op leaves V and N at their old values.
    step(0,0,0,16'h0000,16'h0,1,4'b0000,3'b100,0,0,16'h0002,16'h0002,0,0);
    step(0,0,0,16'h0000,16'h0,1,4'b0010,3'b011,0,0,16'h0004,16'h0004,0,0);
    step(0,0,1,16'hCC00,16'h0,0,4'h0,3'b000,0,0,16'h0006,16'h0006,0,0);
    step(0,0,1,16'hC600,16'h0,0,4'h0,3'b000,0,0,16'h0008,16'h0008,0,0);
    step(0,0,1,16'hC001,16'h0,0,4'h0,3'b000,1,1,16'h000C,16'h000C,0,0);
    step(0,0,0,16'h0000,16'h0,1,4'b0000,3'b011,0,0,16'h000E,16'h000E,0,0);
    step(0,0,0,16'h0000,16'h0,1,4'b0011,3'b100,0,0,16'h0010,16'h0010,0,0);
    step(0,0,1,16'hCC00,16'h0,0,4'h0,3'b000,1,1,16'h0012,16'h0012,0,0);
    step(0,0,1,16'hC600,16'h0,0,4'h0,3'b000,1,1,16'h0014,16'h0014,0,0);
    step(0,0,1,16'hC001,16'h0,0,4'h0,3'b000,0,0,16'h0016,16'h0016,0,0);
    step(0,0,1,16'hC200,16'h0,0,4'h0,3'b000,1,1,16'h0018,16'h0018,0,0);
    step(0,0,1,16'hCA00,16'h0,0,4'h0,3'b000,1,1,16'h001A,16'h001A,0,0);
    step(0,0,1,16'hC400,16'h0,0,4'h0,3'b000,0,0,16'h001C,16'h001C,0,0);
    // fl_op 0111 writes nothing, so Z stays 1 and cond 000 is not taken.
    step(0,0,1,16'hC000,16'h0,1,4'b0111,3'b000,0,0,16'h001E,16'h001E,0,0);
    step(0,0,1,16'hC800,16'h0,0,4'h0,3'b000,1,1,16'h0020,16'h0020,0,0);
    step(0,0,1,16'hEE00,16'h0,0,4'h0,3'b000,0,0,16'h0022,16'h0022,0,0);

    // Wrap at the top of the address space.
    step(0,0,1,16'hDE00,16'hFFFE,0,4'h0,3'b000,1,1,16'hFFFE,16'hFFFE,0,0);
    step(0,0,0,16'h0000,16'h0000,0,4'h0,3'b000,0,0,16'h0000,16'h0000,0,0);

    // Halt: stalled halt ignored, then drain 3 cycles, then HALTED.
    step(0,0,1,16'hDE00,16'h0040,0,4'h0,3'b000,1,1,16'h0040,16'h0040,0,0);
    step(0,1,1,16'hF000,16'h0000,0,4'h0,3'b000,0,0,16'h0040,16'h0040,0,0);
    step(0,0,1,16'hF000,16'h0000,0,4'h0,3'b000,0,0,16'h0040,16'h0040,1,0);
    step(0,0,1,16'hDE00,16'h1234,0,4'h0,3'b000,0,0,16'h0040,16'h0040,1,0);
    step(0,1,0,16'h0000,16'h0000,0,4'h0,3'b000,0,0,16'h0040,16'h0040,1,0);
    step(0,0,0,16'h0000,16'h0000,0,4'h0,3'b000,0,0,16'h0040,16'h0040,0,1);
    step(0,0,1,16'hDE00,16'h1234,0,4'h0,3'b000,0,0,16'h0040,16'h0040,0,1);
    step(1,0,0,16'h0000,16'h0000,0,4'h0,3'b000,0,0,16'h0000,16'h0000,0,0);

    // Reset in the middle of DRAIN.
    step(0,0,1,16'hDE00,16'h0040,0,4'h0,3'b000,1,1,16'h0040,16'h0040,0,0);
    step(0,0,1,16'hF000,16'h0000,0,4'h0,3'b000,0,0,16'h0040,16'h0040,1,0);
    step(0,0,0,16'h0000,16'h0000,0,4'h0,3'b000,0,0,16'h0040,16'h0040,1,0);
    step(1,0,0,16'h0000,16'h0000,0,4'h0,3'b000,0,0,16'h0000,16'h0000,0,0);
    step(0,0,0,16'h0000,16'h0000,0,4'h0,3'b000,0,0,16'h0002,16'h0002,0,0);
    step(0,0,0,16'h0000,16'h0000,0,4'h0,3'b000,0,0,16'h0004,16'h0004,0,0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
